// File: rtl/uart_led_cmd_ctrl.sv
// uart_led_cmd_ctrl: decodes 3-byte UART command frames (A5, CFG, CHK)
// and drives four LEDs as off, on or blinking at one of four rates.
module uart_led_cmd_ctrl #(
    parameter int p_Counter_10Hz = 1250000,
    parameter int p_Counter_5Hz  = 2500000,
    parameter int p_Counter_2Hz  = 6250000,
    parameter int p_Counter_1Hz  = 12500000,
    parameter int p_Timeout_Clks = 250000
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_RX_DV,
    input  logic [7:0] i_RX_Byte,
    output logic       o_Cmd_Ack,
    output logic       o_Cmd_Err,
    output logic       o_LED_1,
    output logic       o_LED_2,
    output logic       o_LED_3,
    output logic       o_LED_4
);
    localparam int TW = $clog2(p_Timeout_Clks);
    localparam logic [7:0] HDR = 8'hA5;
    localparam logic [TW-1:0] GAP_MAX = TW'(p_Timeout_Clks - 1);

    typedef enum logic [1:0] {
        IDLE,
        GET_CFG,
        GET_CHK,
        APPLY
    } state_t;

    state_t        state;
    logic [7:0]    cfg;
    logic [TW-1:0] gap;
    logic [1:0]    mode [4];
    logic [1:0]    rate [4];
    logic [3:0]    phase;
    logic [3:0]    led;

    genvar k;
    for (k = 0; k < 4; k++) begin : g_rate
        localparam int P = (k == 0) ? p_Counter_10Hz :
                           (k == 1) ? p_Counter_5Hz  :
                           (k == 2) ? p_Counter_2Hz  :
                                      p_Counter_1Hz;
        localparam int W = $clog2(P);

        logic [W-1:0] cnt;
        logic         ph;

        // Free-running; commands never disturb the phase.
        always_ff @(posedge i_Clk or negedge i_Rst_L) begin
            if (!i_Rst_L) begin
                cnt <= '0;
                ph  <= 1'b0;
            end else if (cnt == W'(P - 1)) begin
                cnt <= '0;
                ph  <= ~ph;
            end else begin
                cnt <= cnt + W'(1);
            end
        end

        assign phase[k] = ph;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state     <= IDLE;
            cfg       <= '0;
            gap       <= '0;
            o_Cmd_Ack <= 1'b0;
            o_Cmd_Err <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                mode[i] <= 2'b00;
                rate[i] <= 2'b00;
            end
        end else begin
            o_Cmd_Ack <= 1'b0;
            o_Cmd_Err <= 1'b0;
            unique case (state)
                IDLE: begin
                    gap <= '0;
                    if (i_RX_DV && i_RX_Byte == HDR)
                        state <= GET_CFG;
                end
                GET_CFG: begin
                    if (i_RX_DV) begin
                        cfg   <= i_RX_Byte;
                        gap   <= '0;
                        state <= GET_CHK;
                    end else if (gap == GAP_MAX) begin
                        o_Cmd_Err <= 1'b1;
                        gap       <= '0;
                        state     <= IDLE;
                    end else begin
                        gap <= gap + TW'(1);
                    end
                end
                GET_CHK: begin
                    if (i_RX_DV) begin
                        gap <= '0;
                        if (i_RX_Byte == (cfg ^ HDR)) begin
                            state <= APPLY;
                        end else begin
                            o_Cmd_Err <= 1'b1;
                            state     <= IDLE;
                        end
                    end else if (gap == GAP_MAX) begin
                        o_Cmd_Err <= 1'b1;
                        gap       <= '0;
                        state     <= IDLE;
                    end else begin
                        gap <= gap + TW'(1);
                    end
                end
                APPLY: begin
                    for (int i = 0; i < 4; i++) begin
                        if (cfg[4+i]) begin
                            mode[i] <= cfg[1:0];
                            rate[i] <= cfg[3:2];
                        end
                    end
                    o_Cmd_Ack <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Mode 11 is reserved and falls into the OFF default.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            led <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                case (mode[i])
                    2'b01:   led[i] <= 1'b1;
                    2'b10:   led[i] <= phase[rate[i]];
                    default: led[i] <= 1'b0;
                endcase
            end
        end
    end

    assign o_LED_1 = led[0];
    assign o_LED_2 = led[1];
    assign o_LED_3 = led[2];
    assign o_LED_4 = led[3];

endmodule

// File: tb/tb_uart_led_cmd_ctrl.sv
// tb_uart_led_cmd_ctrl: directed frame tests for uart_led_cmd_ctrl
// with an edge-count model of the blink phases.
module tb_uart_led_cmd_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_dv = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       ack;
    logic       err;
    logic       led1, led2, led3, led4;
    logic [3:0] leds;

    int checks = 0;
    int errors = 0;
    int ecount;

    assign leds = {led4, led3, led2, led1};

    uart_led_cmd_ctrl #(
        .p_Counter_10Hz(4),
        .p_Counter_5Hz(6),
        .p_Counter_2Hz(10),
        .p_Counter_1Hz(20),
        .p_Timeout_Clks(50)
    ) dut (
        .i_Clk(clk),
        .i_Rst_L(rst_n),
        .i_RX_DV(rx_dv),
        .i_RX_Byte(rx_byte),
        .o_Cmd_Ack(ack),
        .o_Cmd_Err(err),
        .o_LED_1(led1),
        .o_LED_2(led2),
        .o_LED_3(led3),
        .o_LED_4(led4)
    );

    always #5 clk = ~clk;

    // Rising edges since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecount <= 0;
        else ecount <= ecount + 1;
    end

    // Expected blink LED value sampled after edge ecount.
    function automatic logic ph(input int p);
        return (((ecount - 1) / p) % 2) == 1;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        rx_byte = b;
        rx_dv = 1'b1;
        @(negedge clk);
        rx_dv = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] s);
        send_byte(8'hA5);
        send_byte(c);
        send_byte(s);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if ({ack, err, leds} !== 6'b0) begin
            errors++;
            $display("FAIL reset_hold: got %b want 000000", {ack, err, leds});
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({ack, err, leds} !== 6'b0) begin
            errors++;
            $display("FAIL reset_post: got %b want 000000", {ack, err, leds});
        end
    endtask

    task automatic test_on;
        send_frame(8'h11, 8'hB4);
        checks++;
        if (ack !== 1'b0) begin
            errors++;
            $display("FAIL on_ack_early: got %b want 0", ack);
        end
        @(negedge clk);
        checks++;
        if (ack !== 1'b1 || leds !== 4'b0000) begin
            errors++;
            $display("FAIL on_ack: ack %b leds %b want 1 0000", ack, leds);
        end
        @(negedge clk);
        checks++;
        if (ack !== 1'b0 || leds !== 4'b0001) begin
            errors++;
            $display("FAIL on_led: ack %b leds %b want 0 0001", ack, leds);
        end
    endtask

    task automatic test_blink;
        logic [3:0] exp;
        send_frame(8'hF2, 8'h57);
        @(negedge clk);
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("FAIL blink_ack: got %b want 1", ack);
        end
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            exp = {4{ph(4)}};
            checks++;
            if (leds !== exp) begin
                errors++;
                $display("FAIL blink_r0 @%0d: got %b want %b", ecount, leds, exp);
            end
            @(negedge clk);
        end
        send_frame(8'h8E, 8'h2B);
        @(negedge clk);
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("FAIL rate3_ack: got %b want 1", ack);
        end
        @(negedge clk);
        for (int i = 0; i < 45; i++) begin
            exp = {ph(20), ph(4), ph(4), ph(4)};
            checks++;
            if (leds !== exp) begin
                errors++;
                $display("FAIL blink_r3 @%0d: got %b want %b", ecount, leds, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_bad_chk;
        logic [3:0] exp;
        send_frame(8'h11, 8'h00);
        checks++;
        if (err !== 1'b1 || ack !== 1'b0) begin
            errors++;
            $display("FAIL chk_err: err %b ack %b want 1 0", err, ack);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || ack !== 1'b0) begin
            errors++;
            $display("FAIL chk_err_pulse: err %b ack %b want 0 0", err, ack);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            exp = {ph(20), ph(4), ph(4), ph(4)};
            checks++;
            if (leds !== exp || ack !== 1'b0) begin
                errors++;
                $display("FAIL chk_keep: leds %b ack %b want %b 0", leds, ack, exp);
            end
        end
        send_frame(8'h11, 8'hB4);
        @(negedge clk);
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("FAIL recover_ack: got %b want 1", ack);
        end
        @(negedge clk);
        exp = {ph(20), ph(4), ph(4), 1'b1};
        checks++;
        if (leds !== exp) begin
            errors++;
            $display("FAIL recover_led: got %b want %b", leds, exp);
        end
    endtask

    task automatic test_timeout;
        int bad;
        bad = 0;
        send_byte(8'hA5);
        send_byte(8'h21);
        for (int i = 1; i < 50; i++) begin
            @(negedge clk);
            if (err !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL timeout_early: %0d err cycles want 0", bad);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_err: got %b want 1", err);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: got %b want 0", err);
        end
        bad = 0;
        send_byte(8'h84);
        repeat (3) begin
            if (ack !== 1'b0 || err !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL late_byte: %0d ack/err cycles want 0", bad);
        end
    endtask

    task automatic test_expiry_dv;
        send_byte(8'hA5);
        send_byte(8'h21);
        repeat (49) @(negedge clk);
        send_byte(8'h84);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL expiry_err: got %b want 0", err);
        end
        @(negedge clk);
        checks++;
        if (ack !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL expiry_ack: ack %b err %b want 1 0", ack, err);
        end
        @(negedge clk);
        checks++;
        if (leds[1:0] !== 2'b11) begin
            errors++;
            $display("FAIL expiry_led: got %b want 11", leds[1:0]);
        end
    endtask

    task automatic test_back_to_back;
        int bad;
        send_byte(8'hA5);
        send_byte(8'h41);
        send_byte(8'hE4);
        send_byte(8'hA5);
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ack: got %b want 1", ack);
        end
        @(negedge clk);
        checks++;
        if (leds[2:0] !== 3'b111) begin
            errors++;
            $display("FAIL b2b_led: got %b want 111", leds[2:0]);
        end
        bad = 0;
        send_byte(8'h11);
        send_byte(8'hB4);
        repeat (3) begin
            if (ack !== 1'b0 || err !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL apply_dv: %0d ack/err cycles want 0", bad);
        end
    endtask

    task automatic test_mask_zero;
        logic [3:0] exp;
        send_frame(8'h02, 8'hA7);
        @(negedge clk);
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("FAIL mask0_ack: got %b want 1", ack);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            exp = {ph(20), 3'b111};
            checks++;
            if (leds !== exp) begin
                errors++;
                $display("FAIL mask0_led: got %b want %b", leds, exp);
            end
        end
        send_frame(8'h13, 8'hB6);
        @(negedge clk);
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("FAIL rsvd_ack: got %b want 1", ack);
        end
        @(negedge clk);
        exp = {ph(20), 3'b110};
        checks++;
        if (leds !== exp) begin
            errors++;
            $display("FAIL rsvd_led: got %b want %b", leds, exp);
        end
    endtask

    task automatic test_reset_mid;
        int bad;
        send_frame(8'h11, 8'hB4);
        repeat (2) @(negedge clk);
        checks++;
        if (leds[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup: got %b want 1", leds[0]);
        end
        send_byte(8'hA5);
        send_byte(8'h11);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ack, err, leds} !== 6'b0) begin
            errors++;
            $display("FAIL async_rst: got %b want 000000", {ack, err, leds});
        end
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bad = 0;
        send_byte(8'hB4);
        repeat (3) begin
            if (ack !== 1'b0 || leds !== 4'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL lone_chk: %0d bad cycles want 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_on();
        test_blink();
        test_bad_chk();
        test_timeout();
        test_expiry_dv();
        test_back_to_back();
        test_mask_zero();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
